diabetes_input_sequencer: RTL and testbench

// - Upstream stage of the MLP diabetes classifier: debounces SW/KEY, builds 4-digit BCD entries for the 8 fields
//   (Pregnancies..Age), then streams them as integers over valid/ready. Waits for the risk class (0..3) and shows it.
// - Drives the 7-seg nibbles: field index plus 4 BCD digits.

---
 rtl/diabetes_input_sequencer_pkg.sv | 44 ++++
 rtl/diabetes_input_sequencer_if.sv | 28 ++
 rtl/diabetes_input_sequencer_input_debouncer.sv | 80 ++++++++
 rtl/diabetes_input_sequencer.sv | 158 +++++++++++++++
 tb/tb_diabetes_input_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/diabetes_input_sequencer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | diabetes_input_sequencer_pkg                                     |
// | Shared types and constants for the diabetes input sequencer.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package diabetes_input_sequencer_pkg;

    localparam int N_FIELDS = 8;
    localparam int DIGITS   = 4;

    localparam logic [3:0] PREGNANCIES       = 4'd0;
    localparam logic [3:0] GLUCOSE           = 4'd1;
    localparam logic [3:0] BLOOD_PRESSURE    = 4'd2;
    localparam logic [3:0] SKIN_THICKNESS    = 4'd3;
    localparam logic [3:0] INSULIN           = 4'd4;
    localparam logic [3:0] BMI               = 4'd5;
    localparam logic [3:0] DIABETES_PEDIGREE = 4'd6;
    localparam logic [3:0] AGE               = 4'd7;
    localparam logic [3:0] OUTCOME           = 4'd8;

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_SHOW     = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        logic clear;
        logic next;
        logic digit_v;
        bcd_t digit;
    } key_evt_t;

    function automatic logic [13:0] bcd_to_bin(input logic [15:0] bcd);
        return 14'(bcd[15:12]) * 14'd1000 + 14'(bcd[11:8]) * 14'd100
             + 14'(bcd[7:4]) * 14'd10 + 14'(bcd[3:0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/diabetes_input_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | diabetes_input_sequencer_if                                      |
// | Field stream toward the classifier plus its result strobe.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface diabetes_input_sequencer_if #(
    parameter int VAL_W = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_idx;
    logic [VAL_W-1:0] out_value;
    logic             out_last;
    logic             res_valid;
    logic [1:0]       res_class;

    modport master (
        output out_valid, out_idx, out_value, out_last,
        input  out_ready, res_valid, res_class
    );

    modport slave (
        input  out_valid, out_idx, out_value, out_last,
        output out_ready, res_valid, res_class
    );
endinterface
`default_nettype wire

// File: rtl/diabetes_input_sequencer_input_debouncer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | input_debouncer                                                  |
// | Tick-sampled 2-agree debounce with release-gated priority event. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module input_debouncer
    import diabetes_input_sequencer_pkg::*;
#(
    parameter int TICK_BITS = 13,
    parameter int N_SW      = 10
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic [N_SW-1:0] i_sw,
    input  wire logic            i_key_clear_n,
    input  wire logic            i_key_next_n,
    output key_evt_t             o_evt
);
    localparam int c_W = N_SW + 2;

    logic [TICK_BITS-1:0] r_tick_cnt;
    logic [c_W-1:0]       r_sync1, r_sync2, r_sample, r_deb;
    logic                 r_deb_any_d;
    key_evt_t             r_evt, w_evt_dec;
    logic [c_W-1:0]       w_raw;
    logic                 w_tick, w_rise;

    // Bit 1 = clear, bit 0 = next, bits [c_W-1:2] = digit switches; 1 = active
    assign w_raw  = {i_sw, ~i_key_clear_n, ~i_key_next_n};
    assign w_tick = &r_tick_cnt;
    assign w_rise = (|r_deb) & ~r_deb_any_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_cnt  <= '0;
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_sample    <= '0;
            r_deb       <= '0;
            r_deb_any_d <= 1'b0;
            r_evt       <= '0;
        end else begin
            r_tick_cnt  <= r_tick_cnt + TICK_BITS'(1);
            r_sync1     <= w_raw;
            r_sync2     <= r_sync1;
            if (w_tick) begin
                r_sample <= r_sync2;
                if (r_sync2 == r_sample) begin
                    r_deb <= r_sync2;
                end
            end
            r_deb_any_d <= |r_deb;
            r_evt       <= w_evt_dec;
        end
    end

    always_comb begin
        w_evt_dec = '0;
        if (w_rise) begin
            if (r_deb[1]) begin
                w_evt_dec.clear = 1'b1;
            end else if (r_deb[0]) begin
                w_evt_dec.next = 1'b1;
            end else begin
                w_evt_dec.digit_v = 1'b1;
                // Descending scan so the lowest active digit wins
                for (int k = N_SW - 1; k >= 0; k--) begin
                    if (r_deb[k+2]) begin
                        w_evt_dec.digit = bcd_t'(k);
                    end
                end
            end
        end
    end

    assign o_evt = r_evt;

endmodule
`default_nettype wire

// File: rtl/diabetes_input_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | diabetes_input_sequencer                                         |
// | BCD field entry, valid/ready field stream and result display.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module diabetes_input_sequencer #(
    parameter int N_FIELDS  = 8,
    parameter int DIGITS    = 4,
    parameter int VAL_W     = 16,
    parameter int TICK_BITS = 13
) (
    input  wire logic                  ADC_CLK_10,
    input  wire logic                  reset_n,
    input  wire logic [9:0]            SW,
    input  wire logic                  key_clear_n,
    input  wire logic                  key_next_n,
    diabetes_input_sequencer_if.master cls,
    output logic [3:0]                 disp_state,
    output logic [DIGITS*4-1:0]        disp_bcd
);
    import diabetes_input_sequencer_pkg::*;

    localparam int              c_FW   = DIGITS * 4;
    localparam int              c_IW   = $clog2(N_FIELDS);
    localparam logic [c_IW-1:0] c_LAST = c_IW'(N_FIELDS - 1);

    key_evt_t        w_evt;
    state_t          r_state, w_state_nxt;
    logic [c_IW-1:0] r_field, w_field_nxt, r_idx, w_idx_nxt;
    logic [c_FW-1:0] r_digits [N_FIELDS];
    logic            r_valid, w_valid_nxt;
    logic [VAL_W-1:0] r_value;
    logic [1:0]      r_class;
    logic            w_clear, w_shift, w_latch_res, w_out_valid, w_handshake;

    input_debouncer #(
        .TICK_BITS (TICK_BITS),
        .N_SW      (10)
    ) u_input_debouncer (
        .clk           (ADC_CLK_10),
        .rst_n         (reset_n),
        .i_sw          (SW),
        .i_key_clear_n (key_clear_n),
        .i_key_next_n  (key_next_n),
        .o_evt         (w_evt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_field_nxt = r_field;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_clear     = w_evt.clear;
        w_shift     = 1'b0;
        w_latch_res = 1'b0;
        // A clear withdraws the offer in the same cycle so no handshake slips through
        w_out_valid = r_valid & ~w_evt.clear;
        w_handshake = w_out_valid & cls.out_ready;
        case (r_state)
            ST_ENTRY: begin
                if (w_evt.next) begin
                    if (r_field == c_LAST) begin
                        w_state_nxt = ST_SEND;
                        w_idx_nxt   = '0;
                    end else begin
                        w_field_nxt = r_field + 1'b1;
                    end
                end else if (w_evt.digit_v) begin
                    w_shift = 1'b1;
                end
            end
            ST_SEND: begin
                w_valid_nxt = 1'b1;
                if (w_handshake) begin
                    if (r_idx == c_LAST) begin
                        w_state_nxt = ST_WAIT_RES;
                        w_valid_nxt = 1'b0;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            ST_WAIT_RES: begin
                if (cls.res_valid) begin
                    w_state_nxt = ST_SHOW;
                    w_latch_res = 1'b1;
                end
            end
            ST_SHOW: begin
                if (w_evt.next) begin
                    w_clear = 1'b1;
                end
            end
            default: ;
        endcase
        if (w_clear) begin
            w_state_nxt = ST_ENTRY;
            w_field_nxt = '0;
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_shift     = 1'b0;
            w_latch_res = 1'b0;
        end
    end

    always_ff @(posedge ADC_CLK_10) begin
        if (!reset_n) begin
            r_state <= ST_ENTRY;
            r_field <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_value <= '0;
            r_class <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_field <= w_field_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            // Converted from the upcoming index so idx and value move together
            r_value <= (w_state_nxt == ST_SEND) ? VAL_W'(bcd_to_bin(r_digits[w_idx_nxt])) : '0;
            if (w_latch_res) begin
                r_class <= cls.res_class;
            end
        end
    end

    always_ff @(posedge ADC_CLK_10) begin
        if (!reset_n || w_clear) begin
            for (int i = 0; i < N_FIELDS; i++) begin
                r_digits[i] <= '0;
            end
        end else if (w_shift) begin
            r_digits[r_field] <= {r_digits[r_field][c_FW-5:0], w_evt.digit};
        end
    end

    assign cls.out_valid = w_out_valid;
    assign cls.out_idx   = 4'(r_idx);
    assign cls.out_value = r_value;
    assign cls.out_last  = w_out_valid & (r_idx == c_LAST);

    always_comb begin
        disp_state = 4'(N_FIELDS);
        disp_bcd   = '0;
        case (r_state)
            ST_ENTRY: begin
                disp_state = 4'(r_field);
                disp_bcd   = r_digits[r_field];
            end
            ST_SHOW:  disp_bcd = c_FW'(r_class);
            default:  ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_diabetes_input_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_diabetes_input_sequencer                                      |
// | Directed + randomized bench with a field-level reference model.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_diabetes_input_sequencer;

    localparam int TB_HOLD   = 16;
    localparam int TB_SETTLE = 16;
    localparam int M_ENTRY = 0, M_SEND = 1, M_WAIT = 2, M_SHOW = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] sw;
    logic       key_clear_n, key_next_n;
    logic [3:0] disp_state;
    logic [15:0] disp_bcd;

    always #5 clk = ~clk;

    diabetes_input_sequencer_if #(.VAL_W(16)) bus ();

    diabetes_input_sequencer #(
        .N_FIELDS  (8),
        .DIGITS    (4),
        .VAL_W     (16),
        .TICK_BITS (2)
    ) dut (
        .ADC_CLK_10  (clk),
        .reset_n     (reset_n),
        .SW          (sw),
        .key_clear_n (key_clear_n),
        .key_next_n  (key_next_n),
        .cls         (bus.master),
        .disp_state  (disp_state),
        .disp_bcd    (disp_bcd)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: field values kept as plain integers
    int m_state, m_field, m_class;
    int m_val [8];

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] value;
        logic        last;
    } hs_t;
    hs_t hs_q [$];

    bit mon_en     = 1'b1;
    bit stall_prev = 1'b0;
    int stall_viol = 0;
    int p_idx, p_val;

    always @(negedge clk) begin
        if (reset_n !== 1'b1 || !mon_en) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && !(bus.out_valid === 1'b1 && int'(bus.out_idx) == p_idx
                                && int'(bus.out_value) == p_val)) begin
                stall_viol++;
            end
            stall_prev = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
            p_idx = int'(bus.out_idx);
            p_val = int'(bus.out_value);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                hs_q.push_back('{idx: 32'(bus.out_idx), value: 32'(bus.out_value), last: bus.out_last});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    task automatic model_clear();
        foreach (m_val[i]) m_val[i] = 0;
        m_state = M_ENTRY;
        m_field = 0;
    endtask

    task automatic model_event(input bit clr, input bit nxt, input logic [9:0] s);
        int d;
        d = -1;
        for (int k = 9; k >= 0; k--) if (s[k]) d = k;
        if (clr) begin
            model_clear();
        end else if (nxt) begin
            if (m_state == M_ENTRY) begin
                if (m_field == 7) m_state = M_SEND;
                else m_field++;
            end else if (m_state == M_SHOW) begin
                model_clear();
            end
        end else if (d >= 0 && m_state == M_ENTRY) begin
            m_val[m_field] = (m_val[m_field] * 10 + d) % 10000;
        end
    endtask

    task automatic act(input logic [9:0] s, input bit clr, input bit nxt, input int hold);
        @(posedge clk); #1;
        sw = s; key_clear_n = !clr; key_next_n = !nxt;
        repeat (hold) @(posedge clk);
        #1;
        sw = '0; key_clear_n = 1'b1; key_next_n = 1'b1;
        repeat (TB_SETTLE) @(posedge clk);
        #1;
        model_event(clr, nxt, s);
    endtask

    task automatic digit(input int d);
        logic [9:0] m;
        m = 10'b1 << d;
        act(m, 1'b0, 1'b0, TB_HOLD);
    endtask

    task automatic press_next();
        act('0, 1'b0, 1'b1, TB_HOLD);
    endtask

    task automatic check_disp(input string tag);
        int es, eb;
        case (m_state)
            M_ENTRY: begin es = m_field; eb = to_bcd(m_val[m_field]); end
            M_SHOW:  begin es = 8; eb = m_class; end
            default: begin es = 8; eb = 0; end
        endcase
        @(negedge clk);
        check({tag, ".disp_state"}, 32'(disp_state), es);
        check({tag, ".disp_bcd"}, 32'(disp_bcd), eb);
    endtask

    task automatic pulse_res(input int c);
        @(posedge clk); #1;
        bus.res_valid = 1'b1; bus.res_class = 2'(c);
        @(posedge clk); #1;
        bus.res_valid = 1'b0;
        if (m_state == M_WAIT) begin
            m_state = M_SHOW;
            m_class = c;
        end
    endtask

    task automatic stream(input string tag, input bit rnd, input int n_stop, output int cycles);
        hs_q.delete();
        cycles = 0;
        while (hs_q.size() < n_stop && cycles < 200) begin
            @(posedge clk); #1;
            bus.out_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            @(negedge clk); #1;
            cycles++;
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, ".count"}, 32'(hs_q.size()), 32'(n_stop));
        foreach (hs_q[i]) begin
            check({tag, ".idx"}, hs_q[i].idx, 32'(i));
            check({tag, ".value"}, hs_q[i].value, 32'(m_val[i]));
            check({tag, ".last"}, 32'(hs_q[i].last), 32'(i == 7));
        end
    endtask

    task automatic enter_digits(input int v, input int nd);
        for (int p = nd - 1; p >= 0; p--) digit((v / (10 ** p)) % 10);
    endtask

    task automatic finish_stream(input string tag);
        @(negedge clk);
        check({tag, ".valid_drop"}, 32'(bus.out_valid), 0);
        m_state = M_WAIT;
        check_disp({tag, ".wait"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int fv [8];
        int nd [8];
        int cyc;
        fv = '{6, 148, 72, 35, 0, 33, 1000627, 50};
        nd = '{1, 3, 2, 2, 1, 2, 7, 2};

        reset_n = 1'b0; sw = '0; key_clear_n = 1'b1; key_next_n = 1'b1;
        bus.out_ready = 1'b0; bus.res_valid = 1'b0; bus.res_class = '0;
        model_clear();
        m_class = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst.out_valid", 32'(bus.out_valid), 0);
        check("rst.out_idx", 32'(bus.out_idx), 0);
        check("rst.out_value", 32'(bus.out_value), 0);
        check("rst.out_last", 32'(bus.out_last), 0);
        check("rst.disp_state", 32'(disp_state), 0);
        check("rst.disp_bcd", 32'(disp_bcd), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        digit(1); digit(4); digit(8);
        check_disp("f0_148");
        check("f0_148.lit", 32'(disp_bcd), 32'h0148);
        pulse_res(3);
        check_disp("res_in_entry");

        act('0, 1'b1, 1'b0, TB_HOLD);
        check_disp("clear1");
        enter_digits(12345, 5);
        check("five.lit", 32'(disp_bcd), 32'h2345);
        act(10'b1 << 3, 1'b0, 1'b0, 100);
        check_disp("held3");
        act(10'b1010_0000, 1'b0, 1'b0, TB_HOLD);
        check_disp("prio_sw");
        act(10'b10_0000_0000, 1'b1, 1'b1, TB_HOLD);
        check_disp("clear_wins");

        for (int f = 0; f < 8; f++) begin
            enter_digits(fv[f], nd[f]);
            check_disp("entry");
            press_next();
            check_disp("after_next");
        end
        @(negedge clk);
        check("send.stall_valid", 32'(bus.out_valid), 1);
        check("send.stall_value", 32'(bus.out_value), 6);
        stream("s1", 1'b0, 8, cyc);
        check("s1.cycles", 32'(cyc), 8);
        finish_stream("s1");
        digit(5);
        check_disp("digit_in_wait");
        pulse_res(2);
        check_disp("show");
        check("show.lit", 32'(disp_bcd), 32'h0002);
        digit(7);
        check_disp("digit_in_show");
        press_next();
        check_disp("show_next");

        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(4, 0);
            for (int j = 0; j < n; j++) digit($urandom_range(9, 0));
            check_disp("rnd_entry");
            press_next();
        end
        stream("s2", 1'b1, 8, cyc);
        check("s2.stall_viol", 32'(stall_viol), 0);
        finish_stream("s2");
        pulse_res($urandom_range(3, 0));
        check_disp("rnd_show");
        press_next();
        check_disp("rnd_show_next");

        digit(9);
        for (int f = 0; f < 8; f++) press_next();
        stream("s3", 1'b0, 3, cyc);
        @(negedge clk);
        check("s3.stall_idx", 32'(bus.out_idx), 3);
        check("s3.stall_valid", 32'(bus.out_valid), 1);
        mon_en = 1'b0;
        act('0, 1'b1, 1'b0, TB_HOLD);
        @(negedge clk);
        check("clr_send.valid", 32'(bus.out_valid), 0);
        check_disp("clr_send");
        pulse_res(1);
        check_disp("res_after_clear");
        mon_en = 1'b1;

        digit(4);
        for (int f = 0; f < 8; f++) press_next();
        @(negedge clk);
        check("pre_rst.valid", 32'(bus.out_valid), 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst.out_valid", 32'(bus.out_valid), 0);
        check("mid_rst.out_idx", 32'(bus.out_idx), 0);
        check("mid_rst.out_value", 32'(bus.out_value), 0);
        check("mid_rst.disp_state", 32'(disp_state), 0);
        check("mid_rst.disp_bcd", 32'(disp_bcd), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_clear();
        check_disp("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
